xor_crc_unit: RTL and testbench
===============================

# xor_crc_unit

Parametrised CRC engine built on XOR reduction: accepts a stream of DATA_W-bit beats over a valid/ready handshake, folds each beat into a CRC_W-bit LFSR register, and presents the finished checksum on a second valid/ready handshake at end of message. It sits in the datapath library as the sequential, multi-bit successor to the single XOR gate, and is the checksum stage for framed serial traffic.

## Interface
- CRC_W, 8: CRC register width, 1..32
- DATA_W, 8: bits consumed per accepted beat, 1..64
- POLY, 8'h07: generator polynomial, implicit x^CRC_W term omitted
- INIT, 0: CRC register seed at reset, clear and message start
- XOROUT, all ones: final XOR mask, applied only when the Configuration macro is defined
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort; returns the block to IDLE
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when high with in_valid
- in_data  in  DATA_W  beat data, MSB processed first
- in_last  in  1  marks final beat of message
- out_valid  out  1  checksum available
- out_ready  in  1  consumer takes checksum
- out_crc  out  CRC_W  finished checksum
- out_beats  out  16  beats in the message, saturating
- busy  out  1  high in ACCUM or HOLD

## Operation
- States: IDLE (no beats taken), ACCUM (≥1 beat taken, no last), HOLD (result presented).
- Beat accept: in_valid && in_ready. in_ready = (state != HOLD); registered, no combinational path from out_ready.
- Per beat, crc_next = DATA_W iterations MSB-first of: fb = crc[CRC_W-1] ^ d[i]; crc = {crc[CRC_W-2:0],0} ^ (fb ? POLY : 0).
- IDLE: accept without last -> ACCUM; accept with last -> HOLD.
- ACCUM: accept without last -> stay; accept with last -> HOLD.
- HOLD: out_valid=1, out_crc and out_beats stable until out_ready. On out_valid && out_ready: crc <- INIT, beat count <- 0, -> IDLE.
- Beat counter: increments per accepted beat, saturates at 16'hFFFF, out_beats reflects count including last beat.
- clr: priority over everything except reset; crc <- INIT, count <- 0, out_valid <- 0, -> IDLE. A beat presented with clr is discarded.
- Reset values: state IDLE, crc INIT, out_crc 0, out_beats 0, out_valid 0, in_ready 1, busy 0.
- rst_n low mid-message or in HOLD: all state lost immediately, no checksum produced.
- Zero-beat messages do not exist; in_last without in_valid is ignored.

## Timing
- One beat per cycle sustained in IDLE/ACCUM.
- Last beat accepted at edge N -> out_valid high after edge N, visible cycle N+1.
- Checksum handshake at edge M -> in_ready high cycle M+1; earliest next beat accept at edge M+1. Minimum message turnaround: message beats + 1 cycle when out_ready held high.
- out_crc, out_beats registered; no combinational input-to-output paths.

## Configuration
- XOR_CRC_UNIT_XOROUT_EN defined: out_crc = crc ^ XOROUT[CRC_W-1:0].
- Undefined: out_crc = raw crc register; XOROUT parameter ignored.
- Internal register, state machine and beat counting identical either way.

## Structure
- Package xor_crc_pkg: state typedef (IDLE, ACCUM, HOLD), BEAT_CNT_W = 16, named default constants CRC8_POLY = 8'h07, CRC16_CCITT_POLY = 16'h1021.
- Sub-module xor_crc_step: purely combinational, parameters CRC_W, DATA_W, POLY; inputs crc, data; output crc_next. Instantiated once in the top block; reusable for unrolled checkers.

## Test plan
- Defaults, macro undefined, beats 0x31..0x39 with in_last on 0x39, out_ready high -> out_crc 0xF4, out_beats 9, out_valid one cycle, in_ready high next cycle.
- Single beat 0x01 with in_last -> out_crc 0x07, out_beats 1; with XOR_CRC_UNIT_XOROUT_EN -> out_crc 0xF8.
- out_ready low 5 cycles in HOLD with in_valid high -> in_ready 0, out_crc stable 0xF4, no beat accepted; release -> IDLE, next message computes from INIT.
- clr asserted after 4 of 9 beats, then full "123456789" -> out_crc 0xF4, out_beats 9.
- rst_n pulsed low mid-message and during HOLD -> out_valid 0, busy 0, out_crc 0, in_ready 1 immediately (asynchronous), no stale result after release.
- CRC_W=16, DATA_W=8, POLY=16'h1021, INIT=16'hFFFF, "123456789" -> out_crc 0x29B1.

Source files
------------

// File: rtl/xor_crc_pkg.sv
// Shared types and constants for the XOR-reduction CRC engine and its step function.
package xor_crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } crc_state_t;

  localparam int BEAT_CNT_W = 16;

  localparam logic [7:0]  CRC8_POLY        = 8'h07;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;

endpackage

// File: rtl/xor_crc_step.sv
// Folds one DATA_W-bit beat, MSB first, into a CRC_W-bit LFSR value.
// Latency: purely combinational. Backpressure: none, no handshake.
module xor_crc_step
  import xor_crc_pkg::*;
#(
  parameter int               CRC_W  = 8,
  parameter int               DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC8_POLY)
) (
  input  logic [CRC_W-1:0]  crc,
  input  logic [DATA_W-1:0] data,
  output logic [CRC_W-1:0]  crc_next
);

  logic [CRC_W-1:0] c;
  logic             fb;

  // Shift-left form keeps CRC_W == 1 legal (no empty part-select).
  always_comb begin
    c  = crc;
    fb = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    crc_next = c;
  end

endmodule

// File: rtl/xor_crc_unit.sv
// Streaming CRC engine: one beat/cycle in, checksum presented the cycle after the last beat.
// Backpressure: in_ready (registered) drops only while the result waits in HOLD for out_ready.
// Optional final XOR mask enabled by defining XOR_CRC_UNIT_XOROUT_EN.
module xor_crc_unit
  import xor_crc_pkg::*;
#(
  parameter int               CRC_W  = 8,
  parameter int               DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC8_POLY),
  parameter logic [CRC_W-1:0] INIT   = '0,
  parameter logic [CRC_W-1:0] XOROUT = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CRC_W-1:0]      out_crc,
  output logic [BEAT_CNT_W-1:0] out_beats,
  output logic                  busy
);

`ifdef XOR_CRC_UNIT_XOROUT_EN
  localparam bit XOROUT_EN = 1'b1;
`else
  localparam bit XOROUT_EN = 1'b0;
`endif
  localparam logic [CRC_W-1:0] FINAL_MASK = XOROUT_EN ? XOROUT : '0;

  crc_state_t            state;
  logic [CRC_W-1:0]      crc;
  logic [CRC_W-1:0]      crc_next;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic [BEAT_CNT_W-1:0] cnt_inc;
  logic                  accept;

  xor_crc_step #(
    .CRC_W  (CRC_W),
    .DATA_W (DATA_W),
    .POLY   (POLY)
  ) u_step (
    .crc      (crc),
    .data     (in_data),
    .crc_next (crc_next)
  );

  assign accept  = in_valid && in_ready;
  assign cnt_inc = (beat_cnt == '1) ? beat_cnt : beat_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      crc       <= INIT;
      beat_cnt  <= '0;
      out_crc   <= '0;
      out_beats <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      crc       <= INIT;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            crc      <= crc_next;
            beat_cnt <= cnt_inc;
            busy     <= 1'b1;
            if (in_last) begin
              state     <= HOLD;
              out_crc   <= crc_next ^ FINAL_MASK;
              out_beats <= cnt_inc;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          // Result stays frozen until the consumer takes it.
          if (out_ready) begin
            state     <= IDLE;
            crc       <= INIT;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          crc       <= INIT;
          beat_cnt  <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_crc_unit.sv
// Directed bench for xor_crc_unit: CRC-8 default instance plus a CRC-16/CCITT instance.
module tb_xor_crc_unit;
  import xor_crc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_crc;
  logic [15:0] out_beats;
  logic        busy;

  logic        c16_clr;
  logic        c16_in_valid;
  logic        c16_in_ready;
  logic [7:0]  c16_in_data;
  logic        c16_in_last;
  logic        c16_out_valid;
  logic        c16_out_ready;
  logic [15:0] c16_out_crc;
  logic [15:0] c16_out_beats;
  logic        c16_busy;

  int tests;
  int fails;
  int stall_cycles;

  logic [7:0] msg [9];

`ifdef XOR_CRC_UNIT_XOROUT_EN
  localparam logic [7:0]  EXP_FULL  = 8'h0B;
  localparam logic [7:0]  EXP_ONE   = 8'hF8;
  localparam logic [7:0]  EXP_ZERO  = 8'hFF;
  localparam logic [15:0] EXP_C16   = 16'hD64E;
`else
  localparam logic [7:0]  EXP_FULL  = 8'hF4;
  localparam logic [7:0]  EXP_ONE   = 8'h07;
  localparam logic [7:0]  EXP_ZERO  = 8'h00;
  localparam logic [15:0] EXP_C16   = 16'h29B1;
`endif

  xor_crc_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_crc   (out_crc),
    .out_beats (out_beats),
    .busy      (busy)
  );

  xor_crc_unit #(
    .CRC_W  (16),
    .DATA_W (8),
    .POLY   (CRC16_CCITT_POLY),
    .INIT   (16'hFFFF)
  ) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (c16_clr),
    .in_valid  (c16_in_valid),
    .in_ready  (c16_in_ready),
    .in_data   (c16_in_data),
    .in_last   (c16_in_last),
    .out_valid (c16_out_valid),
    .out_ready (c16_out_ready),
    .out_crc   (c16_out_crc),
    .out_beats (c16_out_beats),
    .busy      (c16_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one beat from a negedge and let the next posedge take it.
  task automatic drive_beat(input logic [7:0] d, input logic l);
    int tries;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tries    = 0;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
      stall_cycles++;
    end
    if (tries == 20) begin
      tests++; fails++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic send_full_msg();
    for (int i = 0; i < 9; i++) drive_beat(msg[i], i == 8);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
    tests++; if (out_crc !== 8'h00)   begin fails++; $display("FAIL rst_out_crc got %h want 00", out_crc); end
    tests++; if (out_beats !== 16'd0) begin fails++; $display("FAIL rst_out_beats got %0d want 0", out_beats); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    out_ready    = 1'b1;
    stall_cycles = 0;
    send_full_msg();
    tests++; if (stall_cycles !== 0)  begin fails++; $display("FAIL basic_stall got %0d want 0", stall_cycles); end
    tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL basic_out_valid got %b want 1", out_valid); end
    tests++; if (out_crc !== EXP_FULL) begin fails++; $display("FAIL basic_crc got %h want %h", out_crc, EXP_FULL); end
    tests++; if (out_beats !== 16'd9) begin fails++; $display("FAIL basic_beats got %0d want 9", out_beats); end
    tests++; if (in_ready !== 1'b0)   begin fails++; $display("FAIL basic_ready_hold got %b want 0", in_ready); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL basic_valid_pulse got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL basic_ready_next got %b want 1", in_ready); end
    tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL basic_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive_beat(8'h01, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests++; if (out_valid !== 1'b1)  begin fails++; $display("FAIL single_valid got %b want 1", out_valid); end
    tests++; if (out_crc !== EXP_ONE) begin fails++; $display("FAIL single_crc got %h want %h", out_crc, EXP_ONE); end
    tests++; if (out_beats !== 16'd1) begin fails++; $display("FAIL single_beats got %0d want 1", out_beats); end
    @(negedge clk);
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    send_full_msg();
    in_valid = 1'b1;
    in_data  = 8'hAA;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (in_ready !== 1'b0)    begin fails++; $display("FAIL hold_ready[%0d] got %b want 0", i, in_ready); end
      tests++; if (out_valid !== 1'b1)   begin fails++; $display("FAIL hold_valid[%0d] got %b want 1", i, out_valid); end
      tests++; if (out_crc !== EXP_FULL) begin fails++; $display("FAIL hold_crc[%0d] got %h want %h", i, out_crc, EXP_FULL); end
      tests++; if (out_beats !== 16'd9)  begin fails++; $display("FAIL hold_beats[%0d] got %0d want 9", i, out_beats); end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hold_release_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL hold_release_ready got %b want 1", in_ready); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL hold_release_busy got %b want 0", busy); end
    drive_beat(8'h01, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests++; if (out_crc !== EXP_ONE) begin fails++; $display("FAIL hold_next_crc got %h want %h", out_crc, EXP_ONE); end
    tests++; if (out_beats !== 16'd1) begin fails++; $display("FAIL hold_next_beats got %0d want 1", out_beats); end
    @(negedge clk);
  endtask

  task automatic test_clr();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_beat(msg[i], 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    clr      = 1'b1;
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL clr_busy got %b want 0", busy); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clr_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL clr_ready got %b want 1", in_ready); end
    send_full_msg();
    tests++; if (out_crc !== EXP_FULL) begin fails++; $display("FAIL clr_crc got %h want %h", out_crc, EXP_FULL); end
    tests++; if (out_beats !== 16'd9)  begin fails++; $display("FAIL clr_beats got %0d want 9", out_beats); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_beat(msg[i], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL arst_mid_busy got %b want 0", busy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL arst_mid_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    send_full_msg();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL arst_pre_valid got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_hold_valid got %b want 0", out_valid); end
    tests++; if (out_crc !== 8'h00)  begin fails++; $display("FAIL arst_hold_crc got %h want 00", out_crc); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL arst_hold_busy got %b want 0", busy); end
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL arst_hold_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL arst_stale_valid got %b want 0", out_valid); end
    out_ready = 1'b1;
    drive_beat(8'h01, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests++; if (out_crc !== EXP_ONE) begin fails++; $display("FAIL arst_after_crc got %h want %h", out_crc, EXP_ONE); end
    tests++; if (out_beats !== 16'd1) begin fails++; $display("FAIL arst_after_beats got %0d want 1", out_beats); end
    @(negedge clk);
  endtask

  task automatic test_crc16();
    int tries;
    c16_out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      c16_in_valid = 1'b1;
      c16_in_data  = msg[i];
      c16_in_last  = (i == 8);
      tries = 0;
      while (!c16_in_ready && tries < 20) begin
        @(negedge clk);
        tries++;
      end
      if (tries == 20) begin
        tests++; fails++;
        $display("FAIL c16_accept_timeout in_ready=%b required 1", c16_in_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    c16_in_valid = 1'b0;
    c16_in_last  = 1'b0;
    tests++; if (c16_out_valid !== 1'b1) begin fails++; $display("FAIL c16_valid got %b want 1", c16_out_valid); end
    tests++; if (c16_out_crc !== EXP_C16) begin fails++; $display("FAIL c16_crc got %h want %h", c16_out_crc, EXP_C16); end
    tests++; if (c16_out_beats !== 16'd9) begin fails++; $display("FAIL c16_beats got %0d want 9", c16_out_beats); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h00;
    in_last  = 1'b0;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL sat_busy got %b want 1", busy); end
    in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tests++; if (out_valid !== 1'b1)      begin fails++; $display("FAIL sat_valid got %b want 1", out_valid); end
    tests++; if (out_beats !== 16'hFFFF)  begin fails++; $display("FAIL sat_beats got %h want ffff", out_beats); end
    tests++; if (out_crc !== EXP_ZERO)    begin fails++; $display("FAIL sat_crc got %h want %h", out_crc, EXP_ZERO); end
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    stall_cycles = 0;
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    c16_clr       = 1'b0;
    c16_in_valid  = 1'b0;
    c16_in_data   = 8'h00;
    c16_in_last   = 1'b0;
    c16_out_ready = 1'b1;

    test_reset();
    test_basic();
    test_single();
    test_hold();
    test_clr();
    test_async_reset();
    test_crc16();
    test_saturation();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
